// File: rtl/pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard
//
// Hazard scoreboard for the in-order pipelined CPU. It tracks the destination
// registers of instructions in flight between ID and WB. For each ID source
// port it selects a forwarding source. It raises a load-use stall when a
// source depends on a load whose data is not yet available. A branch flush
// from EXE discards the ID instruction, so a bubble enters the scoreboard in
// its place.
//
// Slot k holds the instruction in the pipeline register after stage k:
//   slot 0 = EXE ... slot N_STAGES-1 = WB.
//
// Optional feature macro: PIPE_SB_PERF_CNT_EN adds the stall_cnt and
// flush_cnt performance counter ports and registers.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   id_valid    in   ID holds a valid instruction
//   id_rd_en    in   [N_RD]        per-port source read enable
//   id_rd_addr  in   [N_RD*ADDR_W] source addresses, port i at [i*ADDR_W +: ADDR_W]
//   id_wr_en    in   ID instruction writes a register
//   id_wr_addr  in   [ADDR_W]      ID destination address
//   id_is_load  in   ID instruction is a load
//   flush       in   branch taken in EXE; drop the ID instruction
//   stall       out  hold IF/ID and PC; insert a bubble into ID/EXE
//   fwd_sel     out  [N_RD*SEL_W]  per port: 0 = regfile, s+1 = slot s result
//   stall_cnt   out  [32] stalled cycles        (PIPE_SB_PERF_CNT_EN only)
//   flush_cnt   out  [32] flush cycles          (PIPE_SB_PERF_CNT_EN only)
//
// Handshake: none. Slots shift every cycle with no back-pressure. stall and
// fwd_sel are combinational from the current slots and the ID inputs.
// ---------------------------------------------------------------------------
module pipe_scoreboard #(
  parameter int ADDR_W       = 5,
  parameter int N_STAGES     = 3,
  parameter int N_RD         = 3,
  parameter int LOAD_USE_GAP = 1,
  parameter int HARD_ZERO    = 0,
  parameter int SEL_W        = $clog2(N_STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [N_RD-1:0]          id_rd_en,
  input  logic [N_RD*ADDR_W-1:0]   id_rd_addr,
  input  logic                     id_wr_en,
  input  logic [ADDR_W-1:0]        id_wr_addr,
  input  logic                     id_is_load,
  input  logic                     flush,
  output logic                     stall,
  output logic [N_RD*SEL_W-1:0]    fwd_sel
`ifdef PIPE_SB_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt
`endif
);

  logic [N_STAGES-1:0] slot_valid;
  logic [N_STAGES-1:0] slot_load;
  logic [ADDR_W-1:0]   slot_waddr [N_STAGES];

  logic [N_RD-1:0]     hazard;
  logic                accept;

  // The ID instruction enters slot 0 only when it is really issued: a
  // stalled or flushed instruction becomes a bubble.
  assign accept = id_valid & id_wr_en & ~stall & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      slot_load  <= '0;
      for (int k = 0; k < N_STAGES; k++) slot_waddr[k] <= '0;
    end else begin
      for (int k = 1; k < N_STAGES; k++) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_load[k]  <= slot_load[k-1];
        slot_waddr[k] <= slot_waddr[k-1];
      end
      slot_valid[0] <= accept;
      slot_load[0]  <= accept & id_is_load;
      slot_waddr[0] <= id_wr_addr;
    end
  end

  // Per-port youngest-match search. Scanning from the oldest slot down to
  // slot 0 lets the last hit (lowest index, youngest producer) win.
  always_comb begin : match_search
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic              hit_load;
    int                hit_slot;
    hazard  = '0;
    fwd_sel = '0;
    for (int i = 0; i < N_RD; i++) begin
      addr     = id_rd_addr[i*ADDR_W +: ADDR_W];
      hit      = 1'b0;
      hit_load = 1'b0;
      hit_slot = 0;
      for (int s = N_STAGES - 1; s >= 0; s--) begin
        if (id_rd_en[i] && slot_valid[s] && (slot_waddr[s] == addr) &&
            !((HARD_ZERO != 0) && (addr == '0))) begin
          hit      = 1'b1;
          hit_load = slot_load[s];
          hit_slot = s;
        end
      end
      if (hit) begin
        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(hit_slot + 1);
        // A load in a slot below LOAD_USE_GAP has no data yet to forward.
        hazard[i] = hit_load && (hit_slot < LOAD_USE_GAP);
      end
    end
  end

  // Flush beats stall: the ID instruction is being discarded anyway.
  assign stall = id_valid & ~flush & (|hazard);

`ifdef PIPE_SB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_pipe_scoreboard
//
// Directed-vector bench for pipe_scoreboard with default parameters
// (ADDR_W=5, N_STAGES=3, N_RD=3, LOAD_USE_GAP=1, HARD_ZERO=0, SEL_W=2).
// The driver applies one ID vector per cycle and pushes the hand-computed
// {stall, fwd_sel} (plus the counters when PIPE_SB_PERF_CNT_EN is defined)
// into exp_q. The monitor pops and compares on every falling edge while the
// driver presents a vector.
// ---------------------------------------------------------------------------
module tb_pipe_scoreboard;

  localparam int ADDR_W = 5;
  localparam int N_RD   = 3;
  localparam int SEL_W  = 2;
  localparam int BASE_W = 1 + N_RD * SEL_W;
`ifdef PIPE_SB_PERF_CNT_EN
  localparam int EW = BASE_W + 64;
`else
  localparam int EW = BASE_W;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   id_valid   = 1'b0;
  logic [N_RD-1:0]        id_rd_en   = '0;
  logic [N_RD*ADDR_W-1:0] id_rd_addr = '0;
  logic                   id_wr_en   = 1'b0;
  logic [ADDR_W-1:0]      id_wr_addr = '0;
  logic                   id_is_load = 1'b0;
  logic                   flush      = 1'b0;
  logic                   stall;
  logic [N_RD*SEL_W-1:0]  fwd_sel;
`ifdef PIPE_SB_PERF_CNT_EN
  logic [31:0]            stall_cnt;
  logic [31:0]            flush_cnt;
`endif

  pipe_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rd_en   (id_rd_en),
    .id_rd_addr (id_rd_addr),
    .id_wr_en   (id_wr_en),
    .id_wr_addr (id_wr_addr),
    .id_is_load (id_is_load),
    .flush      (flush),
    .stall      (stall),
    .fwd_sel    (fwd_sel)
`ifdef PIPE_SB_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic          sample_req = 1'b0;
  logic          done       = 1'b0;
  int            checks     = 0;
  int            errors     = 0;
  int unsigned   m_stall_cnt = 0;
  int unsigned   m_flush_cnt = 0;

  // ---------------- driver ----------------
  // r  : reset level for this cycle
  // mr : pulse reset asynchronously partway through this cycle
  // es/e0/e1/e2 : expected stall and per-port fwd_sel
  task automatic cyc(input bit r, input bit mr,
                     input bit v, input logic [2:0] re,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                     input bit we, input logic [4:0] wa, input bit ld, input bit fl,
                     input bit es, input logic [1:0] e0, input logic [1:0] e1,
                     input logic [1:0] e2);
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    rst        = r;
    id_valid   = v;
    id_rd_en   = re;
    id_rd_addr = {a2, a1, a0};
    id_wr_en   = we;
    id_wr_addr = wa;
    id_is_load = ld;
    flush      = fl;
    if (r || mr) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end
`ifdef PIPE_SB_PERF_CNT_EN
    e = {es, e2, e1, e0, m_stall_cnt, m_flush_cnt};
`else
    e = {es, e2, e1, e0};
`endif
    exp_q.push_back(e);
    sample_req = 1'b1;
    if (mr) begin
      #2;
      rst = 1'b1;
    end
    // Counter model: values seen next cycle include this cycle's events.
    if (!r && !mr) begin
      m_stall_cnt = m_stall_cnt + (es ? 1 : 0);
      m_flush_cnt = m_flush_cnt + (fl ? 1 : 0);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp_v;
`ifdef PIPE_SB_PERF_CNT_EN
    got = {stall, fwd_sel, stall_cnt, flush_cnt};
`else
    got = {stall, fwd_sel};
`endif
    if (sample_req) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL underflow check %0d: got %h, no expected entry", checks, got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          errors = errors + 1;
          $display("FAIL vector check %0d: got %h required %h", checks, got, exp_v);
        end
      end
    end else if (done && exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL leftover: got %0d unchecked entries required 0", exp_q.size());
      exp_q.delete();
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    //   r  mr v  re      a0 a1 a2 we wa ld fl  es e0 e1 e2
    // reset held: nothing tracked, outputs idle
    cyc(1, 0, 1, 3'b111, 3, 4, 0, 1, 3, 0, 0,  0, 0, 0, 0);
    // no producers in flight, read r3/r4
    cyc(0, 0, 1, 3'b011, 3, 4, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // add r5 issued
    cyc(0, 0, 1, 3'b011, 1, 2, 0, 1, 5, 0, 0,  0, 0, 0, 0);
    // read r5 from EXE, MEM, WB in turn
    cyc(0, 0, 1, 3'b001, 5, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
    cyc(0, 0, 1, 3'b001, 5, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0);
    cyc(0, 0, 1, 3'b001, 5, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0);
    // lw r7; add r8,r7,r7 stalls one cycle then forwards from MEM
    cyc(0, 0, 1, 3'b001, 1, 0, 0, 1, 7, 1, 0,  0, 0, 0, 0);
    cyc(0, 0, 1, 3'b011, 7, 7, 0, 1, 8, 0, 0,  1, 1, 1, 0);
    cyc(0, 0, 1, 3'b011, 7, 7, 0, 1, 8, 0, 0,  0, 2, 2, 0);
    // r2 in slots 0 and 2; youngest wins; r8 has retired
    cyc(0, 0, 1, 3'b000, 0, 0, 0, 1, 2, 0, 0,  0, 0, 0, 0);
    cyc(0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    cyc(0, 0, 1, 3'b000, 0, 0, 0, 1, 2, 0, 0,  0, 0, 0, 0);
    cyc(0, 0, 1, 3'b101, 8, 0, 2, 0, 0, 0, 0,  0, 0, 0, 1);
    // lw r6, then a dependent reader under flush: no stall, dropped
    cyc(0, 0, 1, 3'b001, 2, 0, 0, 1, 6, 1, 0,  0, 2, 0, 0);
    cyc(0, 0, 1, 3'b011, 2, 6, 0, 1, 10, 0, 1, 0, 3, 1, 0);
    // flushed r10 never entered; r6 load now in MEM, no stall
    cyc(0, 0, 1, 3'b011, 10, 6, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    // load in EXE but ID not valid: no stall
    cyc(0, 0, 1, 3'b000, 0, 0, 0, 1, 11, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 3'b001, 11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // fill all three slots
    cyc(0, 0, 1, 3'b000, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 3'b000, 0, 0, 0, 1, 13, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 3'b000, 0, 0, 0, 1, 14, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 3'b111, 14, 13, 12, 1, 15, 1, 0, 0, 1, 2, 3);
    // async reset mid-cycle with a load-use hazard pending
    cyc(0, 1, 1, 3'b111, 15, 14, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    // after release the old destinations read from the regfile
    cyc(0, 0, 1, 3'b111, 15, 14, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    sample_req = 1'b0;
    done       = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
